// File: rtl/irq_source_ctrl_if.sv
// irq_source_ctrl_if: peripheral request, mask and end-of-interrupt inputs
// together with the interrupt code, status and flag outputs of irq_source_ctrl.
// The controller uses the slave modport. The peripherals, the counter and the
// testbench use the master modport.
// The timeout flag is present only when IRQ_TIMEOUT_EN is defined.
interface irq_source_ctrl_if #(
    parameter int NSRC = 7
) ();
    logic [NSRC-1:0] src_req;     // peripheral request lines
    logic            irq_en;      // global issue enable
    logic            mask_we;     // mask register write strobe
    logic [NSRC-1:0] mask_din;    // new mask value, 1 = source enabled
    logic            eirq;        // end-of-interrupt pulse from the counter
    logic            lost_clr;    // clears the sticky lost flag

    logic            irq1;        // code bit 0
    logic            irq2;        // code bit 1
    logic            irq3;        // code bit 2
    logic            busy;        // interrupt issued or in service
    logic [2:0]      in_service;  // code in service, 0 when none
    logic [NSRC-1:0] pending;     // pending requests
    logic [NSRC-1:0] src_done;    // one-hot completion pulse
    logic            lost;        // sticky: request on an already pending source
`ifdef IRQ_TIMEOUT_EN
    logic            timeout;     // sticky: the counter never answered
`endif

    modport slave (
        input  src_req, irq_en, mask_we, mask_din, eirq, lost_clr,
        output irq1, irq2, irq3, busy, in_service, pending, src_done, lost
`ifdef IRQ_TIMEOUT_EN
        , output timeout
`endif
    );

    modport master (
        output src_req, irq_en, mask_we, mask_din, eirq, lost_clr,
        input  irq1, irq2, irq3, busy, in_service, pending, src_done, lost
`ifdef IRQ_TIMEOUT_EN
        , input timeout
`endif
    );
endinterface

// File: rtl/irq_source_ctrl.sv
// irq_source_ctrl: interrupt-source side of the irq1/irq2/irq3 + eirq
// interface. The block latches up to NSRC peripheral requests and masks them.
// It presents the highest pending, unmasked source to the counter as a
// one-cycle 3-bit code. Source i maps to code i+1. No further code is issued
// until the counter answers with eirq.
//
// Optional feature: define IRQ_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT_CYC cycles. An expiry sets the sticky timeout flag and releases the
// controller without a src_done pulse.
module irq_source_ctrl #(
    parameter int NSRC        = 7,
    parameter bit EDGE_DET    = 1'b1,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst,    // asynchronous, active-low
    irq_source_ctrl_if.slave   bus
);

    // Reject configurations that the 3-bit code or the WAIT counter cannot express.
    if (NSRC < 1 || NSRC > 7) begin : g_bad_nsrc
        $error("irq_source_ctrl: NSRC must be in 1..7");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("irq_source_ctrl: TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // waiting for a pending, unmasked source
        ST_ISSUE = 2'd1,   // code driven on irq1..3 for exactly one cycle
        ST_WAIT  = 2'd2,   // counter is servicing; waiting for eirq
        ST_GAP   = 2'd3    // one quiet cycle so the counter can drop its latch
    } state_t;

    // Registers
    state_t          r_state;
    logic [NSRC-1:0] r_prev;        // src_req history for edge detection
    logic [NSRC-1:0] r_pending;
    logic [NSRC-1:0] r_mask;
    logic [NSRC-1:0] r_src_done;
    logic [2:0]      r_in_service;
    logic            r_lost;

    // Combinational signals
    state_t          w_state_nxt;
    logic [NSRC-1:0] w_req;         // new requests captured this cycle
    logic [NSRC-1:0] w_cand;        // pending and enabled
    logic [NSRC-1:0] w_sel_onehot;  // highest candidate, one-hot
    logic [2:0]      w_sel_code;    // highest candidate as a code
    logic [NSRC-1:0] w_done_onehot; // source owning the code in service
    logic [NSRC-1:0] w_clr;         // pending bit consumed by an issue
    logic            w_issue;       // IDLE -> ISSUE this cycle
    logic            w_finish;      // WAIT -> GAP on eirq
    logic            w_expire;      // WAIT -> GAP on timeout
    logic            w_lost_evt;

    assign w_req      = EDGE_DET ? (bus.src_req & ~r_prev) : bus.src_req;
    assign w_cand     = r_pending & r_mask;
    assign w_clr      = w_issue ? w_sel_onehot : '0;
    assign w_lost_evt = EDGE_DET && (|(w_req & r_pending));

    // Pick the highest-index candidate. A later hit in the loop overrides an earlier one.
    always_comb begin
        // NOTE: every variable written in an always_comb gets a default first;
        // a path that leaves one unassigned infers a latch.
        w_sel_code   = 3'd0;
        w_sel_onehot = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (w_cand[i]) begin
                w_sel_code      = 3'(i + 1);
                w_sel_onehot    = '0;
                w_sel_onehot[i] = 1'b1;
            end
        end
    end

    // Map the code in service back to its source for the completion pulse.
    always_comb begin
        w_done_onehot = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_done_onehot[i] = (r_in_service == 3'(i + 1));
        end
    end

`ifdef IRQ_TIMEOUT_EN
    localparam int             CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_wait_cnt;   // WAIT cycles elapsed, 0 in the first one
    logic             r_timeout;

    // Count WAIT cycles. The count restarts whenever the FSM is elsewhere.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // Sticky timeout flag. Only a reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timeout <= 1'b0;
        end else if (w_expire) begin
            r_timeout <= 1'b1;
        end
    end

    assign bus.timeout = r_timeout;
`endif

    // Next-state logic and the issue, finish and expire decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_finish    = 1'b0;
        w_expire    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.irq_en && (|w_cand)) begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.eirq) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_GAP;
                end
`ifdef IRQ_TIMEOUT_EN
                else if (r_wait_cnt == CNT_LAST) begin
                    w_expire    = 1'b1;
                    w_state_nxt = ST_GAP;
                end
`endif
            end
            ST_GAP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: sequential state is written only with non-blocking '<='
            // so every register samples pre-edge values, whatever the block order.
            r_state <= w_state_nxt;
        end
    end

    // Request capture, the mask register and the sticky lost flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev    <= '0;
            r_pending <= '0;
            r_mask    <= '1;
            r_lost    <= 1'b0;
        end else begin
            r_prev    <= bus.src_req;
            // A request arriving on the source being issued re-arms it; the set wins.
            r_pending <= (r_pending & ~w_clr) | w_req;
            if (bus.mask_we) begin
                r_mask <= bus.mask_din;
            end
            if (w_lost_evt) begin
                r_lost <= 1'b1;
            end else if (bus.lost_clr) begin
                r_lost <= 1'b0;
            end
        end
    end

    // Track the code in service and pulse src_done when the counter finishes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_service <= 3'd0;
            r_src_done   <= '0;
        end else begin
            r_src_done <= w_finish ? w_done_onehot : '0;
            if (w_issue) begin
                r_in_service <= w_sel_code;
            end else if (w_finish || w_expire) begin
                r_in_service <= 3'd0;
            end
        end
    end

    assign {bus.irq3, bus.irq2, bus.irq1} = (r_state == ST_ISSUE) ? r_in_service : 3'b000;
    assign bus.busy       = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
    assign bus.in_service = r_in_service;
    assign bus.pending    = r_pending;
    assign bus.src_done   = r_src_done;
    assign bus.lost       = r_lost;

endmodule

// File: tb/tb_irq_source_ctrl.sv
// tb_irq_source_ctrl: directed scenarios followed by randomized traffic for
// irq_source_ctrl. A cycle-level behavioural model is built from the block's
// rules. In that model an in-flight interrupt is a (code, age) pair, and age 0
// is the cycle the code is on the lines. The DUT outputs are compared against
// the model on every falling edge. Hand-computed literals pin the DUT and the
// model at key points of the directed scenarios.
module tb_irq_source_ctrl;

    localparam int NS         = 7;
    localparam int TB_TIMEOUT = 8;

    logic clk;
    logic rst;

    irq_source_ctrl_if #(.NSRC(NS)) bus ();

    irq_source_ctrl #(
        .NSRC        (NS),
        .EDGE_DET    (1'b1),
        .TIMEOUT_CYC (TB_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [NS-1:0] m_pend, m_mask, m_prev, m_done;
    int            m_code;   // 0 = nothing in flight
    int            m_age;    // cycles since the code hit the lines
    logic          m_gap;    // quiet cycle after completion
    logic          m_lost;
    logic          m_to;

    always @(posedge clk or negedge rst) begin : model
        logic [NS-1:0] req, np, nd, bitm;
        int            ncode, nage;
        logic          ngap, nto;
        if (!rst) begin
            m_pend <= '0;
            m_mask <= '1;
            m_prev <= '0;
            m_done <= '0;
            m_code <= 0;
            m_age  <= 0;
            m_gap  <= 1'b0;
            m_lost <= 1'b0;
            m_to   <= 1'b0;
        end else begin
            req   = bus.src_req & ~m_prev;
            np    = m_pend | req;
            nd    = '0;
            ncode = m_code;
            nage  = m_age;
            ngap  = 1'b0;
            nto   = m_to;
            if (m_code != 0) begin
                if (m_age == 0) begin
                    nage = 1;
                end else if (bus.eirq) begin
                    nd[m_code-1] = 1'b1;
                    ncode = 0;
                    ngap  = 1'b1;
                end
`ifdef IRQ_TIMEOUT_EN
                else if (m_age == TB_TIMEOUT) begin
                    nto   = 1'b1;
                    ncode = 0;
                    ngap  = 1'b1;
                end
`endif
                else begin
                    nage = m_age + 1;
                end
            end else if (!m_gap && bus.irq_en && ((m_pend & m_mask) != '0)) begin
                for (int i = 0; i < NS; i++) begin
                    if (m_pend[i] && m_mask[i]) ncode = i + 1;
                end
                bitm = '0;
                bitm[ncode-1] = 1'b1;
                np   = (m_pend & ~bitm) | req;
                nage = 0;
            end
            m_pend <= np;
            m_done <= nd;
            m_code <= ncode;
            m_age  <= nage;
            m_gap  <= ngap;
            m_to   <= nto;
            m_prev <= bus.src_req;
            m_lost <= ((req & m_pend) != '0) ? 1'b1 : (bus.lost_clr ? 1'b0 : m_lost);
            if (bus.mask_we) m_mask <= bus.mask_din;
        end
    end

    function automatic int m_lines();
        return (m_code != 0 && m_age == 0) ? m_code : 0;
    endfunction

    function automatic logic [31:0] dut_lines();
        return {29'd0, bus.irq3, bus.irq2, bus.irq1};
    endfunction

    // Compare every DUT output against the model once per cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc lines",      dut_lines(),     m_lines());
            check("cyc busy",       {31'd0, bus.busy}, {31'd0, m_code != 0});
            check("cyc in_service", {29'd0, bus.in_service}, m_code);
            check("cyc pending",    {25'd0, bus.pending},  {25'd0, m_pend});
            check("cyc src_done",   {25'd0, bus.src_done}, {25'd0, m_done});
            check("cyc lost",       {31'd0, bus.lost},     {31'd0, m_lost});
`ifdef IRQ_TIMEOUT_EN
            check("cyc timeout",    {31'd0, bus.timeout},  {31'd0, m_to});
`endif
        end
    end

    // Literal expectation applied to both the DUT and the model.
    task automatic pin(input string name, input logic [31:0] dut_v,
                       input logic [31:0] mdl_v, input logic [31:0] exp);
        check({name, " dut"},   dut_v, exp);
        check({name, " model"}, mdl_v, exp);
    endtask

    // Advance to just after the next rising edge, which is where inputs change.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cycn(input int n);
        repeat (n) cyc();
    endtask

    initial begin
        rst          = 1'b0;
        bus.src_req  = '0;
        bus.irq_en   = 1'b1;
        bus.mask_we  = 1'b0;
        bus.mask_din = '0;
        bus.eirq     = 1'b0;
        bus.lost_clr = 1'b0;
        #1 cmp_en    = 1'b1;

        // Reset: toggle every request line while the reset is held.
        for (int k = 0; k < 4; k++) begin
            cyc();
            bus.src_req = (k % 2 == 0) ? 7'h7F : 7'h00;
        end
        cyc();
        bus.src_req = '0;
        cyc();
        rst = 1'b1;
        @(negedge clk);
        pin("rst pending", {25'd0, bus.pending}, {25'd0, m_pend}, 32'h0);
        pin("rst busy",    {31'd0, bus.busy},    {31'd0, m_code != 0}, 32'h0);
        pin("rst lines",   dut_lines(),          m_lines(), 32'h0);
        pin("rst lost",    {31'd0, bus.lost},    {31'd0, m_lost}, 32'h0);

        // Single request on source 2.
        cyc(); bus.src_req = 7'h04;                               // cycle 0
        cyc(); @(negedge clk);                                    // cycle 1
        pin("single pending", {25'd0, bus.pending}, {25'd0, m_pend}, 32'h04);
        pin("single lines c1", dut_lines(), m_lines(), 32'h0);
        cyc(); @(negedge clk);                                    // cycle 2
        pin("single lines c2", dut_lines(), m_lines(), 32'h3);
        pin("single busy c2",  {31'd0, bus.busy}, {31'd0, m_code != 0}, 32'h1);
        cycn(4); bus.eirq = 1'b1;                                 // cycle 6
        cyc(); bus.eirq = 1'b0; @(negedge clk);                   // cycle 7
        pin("single done", {25'd0, bus.src_done}, {25'd0, m_done}, 32'h04);
        pin("single busy c7", {31'd0, bus.busy}, {31'd0, m_code != 0}, 32'h0);
        cyc(); bus.src_req = '0;
        cycn(2);

        // Priority: sources 0 and 5 together.
        cyc(); bus.src_req = 7'h21;                               // p0
        cycn(2); @(negedge clk);                                  // p2
        pin("prio first", dut_lines(), m_lines(), 32'h6);
        cyc(); bus.eirq = 1'b1;                                   // p3
        cyc(); bus.eirq = 1'b0; @(negedge clk);                   // p4 gap
        pin("prio done", {25'd0, bus.src_done}, {25'd0, m_done}, 32'h20);
        cycn(2); @(negedge clk);                                  // p6
        pin("prio second", dut_lines(), m_lines(), 32'h1);
        cyc(); bus.eirq = 1'b1;                                   // p7
        cyc(); bus.eirq = 1'b0;                                   // p8
        cyc(); bus.src_req = '0;
        cycn(2);

        // Mask: disable source 0, request it, then re-enable.
        cyc(); bus.mask_din = 7'h7E; bus.mask_we = 1'b1;          // m0
        cyc(); bus.mask_we = 1'b0; bus.src_req = 7'h01;           // m1
        cycn(3); @(negedge clk);                                  // m4
        pin("mask pending", {25'd0, bus.pending}, {25'd0, m_pend}, 32'h01);
        pin("mask busy",    {31'd0, bus.busy}, {31'd0, m_code != 0}, 32'h0);
        cyc(); bus.mask_din = 7'h7F; bus.mask_we = 1'b1;          // m5
        cyc(); bus.mask_we = 1'b0; @(negedge clk);                // m6
        pin("mask lines m6", dut_lines(), m_lines(), 32'h0);
        cyc(); @(negedge clk);                                    // m7
        pin("mask lines m7", dut_lines(), m_lines(), 32'h1);
        cyc(); bus.eirq = 1'b1;                                   // m8
        cyc(); bus.eirq = 1'b0; bus.src_req = '0;                 // m9
        cycn(2);

        // Lost: two edges on source 3 while code 7 is in service.
        cyc(); bus.src_req = 7'h40;                               // l0
        cycn(2); @(negedge clk);                                  // l2
        pin("lost issue", dut_lines(), m_lines(), 32'h7);
        cyc(); bus.src_req = 7'h48;                               // l3
        cyc(); bus.src_req = 7'h40; @(negedge clk);               // l4
        pin("lost pending", {25'd0, bus.pending}, {25'd0, m_pend}, 32'h08);
        cyc(); bus.src_req = 7'h48;                               // l5
        cyc(); @(negedge clk);                                    // l6
        pin("lost set", {31'd0, bus.lost}, {31'd0, m_lost}, 32'h1);
        cyc(); bus.lost_clr = 1'b1;                               // l7
        cyc(); bus.lost_clr = 1'b0; bus.eirq = 1'b1; @(negedge clk); // l8
        pin("lost clr", {31'd0, bus.lost}, {31'd0, m_lost}, 32'h0);
        cyc(); bus.eirq = 1'b0; @(negedge clk);                   // l9
        pin("lost done7", {25'd0, bus.src_done}, {25'd0, m_done}, 32'h40);
        cycn(2); @(negedge clk);                                  // l11
        pin("lost next", dut_lines(), m_lines(), 32'h4);
        cyc(); bus.eirq = 1'b1;                                   // l12
        cyc(); bus.eirq = 1'b0;                                   // l13 gap
        cyc(); bus.eirq = 1'b1;                                   // l14 idle, stray
        cyc(); bus.eirq = 1'b0; @(negedge clk);                   // l15
        pin("stray done", {25'd0, bus.src_done}, {25'd0, m_done}, 32'h0);
        pin("stray busy", {31'd0, bus.busy}, {31'd0, m_code != 0}, 32'h0);
        bus.src_req = '0;
        cycn(2);

`ifdef IRQ_TIMEOUT_EN
        // Timeout: issue code 2 and never answer.
        cyc(); bus.src_req = 7'h02;                               // t0
        cycn(2); @(negedge clk);                                  // t2
        pin("to issue", dut_lines(), m_lines(), 32'h2);
        cycn(8); @(negedge clk);                                  // t10, last WAIT
        pin("to busy t10", {31'd0, bus.busy}, {31'd0, m_code != 0}, 32'h1);
        pin("to flag t10", {31'd0, bus.timeout}, {31'd0, m_to}, 32'h0);
        cyc(); @(negedge clk);                                    // t11
        pin("to flag", {31'd0, bus.timeout}, {31'd0, m_to}, 32'h1);
        pin("to busy", {31'd0, bus.busy}, {31'd0, m_code != 0}, 32'h0);
        pin("to done", {25'd0, bus.src_done}, {25'd0, m_done}, 32'h0);
        bus.src_req = '0;
        cycn(2);
`endif

        // Randomized traffic checked cycle by cycle against the model.
        for (int n = 0; n < 3000; n++) begin
            cyc();
            for (int b = 0; b < NS; b++) begin
                if ($urandom_range(0, 5) == 0) bus.src_req[b] = ~bus.src_req[b];
            end
            bus.irq_en   = (n % 500 < 450) ? ($urandom_range(0, 15) != 0) : 1'b0;
            bus.mask_we  = ($urandom_range(0, 19) == 0);
            bus.mask_din = NS'($urandom);
            bus.eirq     = ($urandom_range(0, 3) == 0);
            bus.lost_clr = ($urandom_range(0, 9) == 0);
        end
        cyc();
        bus.src_req = '0; bus.eirq = 1'b0; bus.mask_we = 1'b0; bus.lost_clr = 1'b0;
        cycn(4);
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/irq_source_ctrl.md
Name: irq_source_ctrl

Overview:
- Interrupt-source side of the processor's irq1/irq2/irq3 + eirq interrupt interface; the counter is the consumer.
- Latches requests from up to 7 peripheral lines and applies a per-source mask.
- Presents the highest-priority pending, unmasked source to the counter as a one-cycle 3-bit code.
- Holds off further issue until the counter signals end of service with eirq.

Parameters:
- NSRC, 7: number of sources, 1..7. Source i maps to code i+1.
- EDGE_DET, 1: 1 = rising-edge capture of src_req; 0 = level capture.
- TIMEOUT_CYC, 1024: WAIT-state cycle limit. Used only with IRQ_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- src_req  in  NSRC  peripheral request lines.
- irq_en  in  1  global enable. 0 blocks new issue; capture continues.
- mask_we  in  1  write strobe for the mask register.
- mask_din  in  NSRC  new mask value. 1 = source enabled.
- eirq  in  1  end-of-interrupt pulse from the counter.
- lost_clr  in  1  clears the lost flag.
- irq1  out  1  code bit 0.
- irq2  out  1  code bit 1.
- irq3  out  1  code bit 2.
- busy  out  1  an interrupt is issued or in service.
- in_service  out  3  code currently in service; 0 when none.
- pending  out  NSRC  pending register.
- src_done  out  NSRC  one-cycle one-hot pulse on the completed source.
- lost  out  1  sticky: a request arrived while that source was already pending.
- timeout  out  1  sticky: a WAIT timeout occurred. Exists only with IRQ_TIMEOUT_EN.

Behaviour:
- Reset (rst=0, async) clears all outputs and registers:
  - irq1..3=0, busy=0, in_service=0, pending=0, src_done=0, lost=0, timeout=0.
  - mask=all 1s; edge-detect history=0; FSM=IDLE.
- Capture, every cycle:
  - req_i = rising edge of src_req[i] (EDGE_DET=1) or src_req[i] (EDGE_DET=0).
  - req_i sets pending[i], masked or not.
  - req_i with pending[i] already 1 sets lost (EDGE_DET=1 only).
  - lost_clr clears lost; a lost event in the same cycle wins.
- Mask: mask_we loads mask_din at the clock edge. It takes effect for selection in the next cycle.
- Selection: sel = highest index i with pending[i] & mask[i]; code = sel+1.
- FSM states: IDLE, ISSUE, WAIT, GAP.
  - IDLE -> ISSUE when irq_en=1 and any pending&mask bit is set. Register code into in_service and clear pending[sel].
    - A new req_i in the same cycle on the selected source keeps pending[sel]=1; set wins.
  - ISSUE, exactly 1 cycle: {irq3,irq2,irq1}=in_service, busy=1. Always -> WAIT.
  - WAIT: irq lines 0, busy=1.
    - On eirq=1: pulse src_done[in_service-1] for 1 cycle, clear in_service, -> GAP.
  - GAP, 1 cycle: busy=0, no issue. Gives the counter one cycle to clear its latched request. -> IDLE.
- irq1..3 are nonzero only in ISSUE. Latency from request capture to code on the lines is 2 cycles: capture in cycle 0, IDLE->ISSUE in cycle 1, lines valid in cycle 2.
- eirq outside WAIT (IDLE, ISSUE, GAP) is ignored. It produces no src_done.
- irq_en deasserted during ISSUE or WAIT does not abort the in-flight interrupt.
- Mask change during WAIT does not affect in_service.
- Back-to-back throughput: at most one interrupt per 3 cycles plus the service time.

Optional Feature:
- Macro: IRQ_TIMEOUT_EN.
- Defined:
  - A WAIT cycle counter runs. On reaching TIMEOUT_CYC without eirq, set timeout (sticky until reset), clear in_service, and -> GAP.
  - No src_done pulse on timeout.
  - A counter width of clog2(TIMEOUT_CYC+1) is sufficient.
- Undefined: WAIT holds indefinitely until eirq, and the timeout port is absent.

Test Plan:
- Reset: hold rst=0 while toggling src_req=7'h7F, then release -> all outputs 0, mask=7'h7F, FSM IDLE.
- Single request: rising edge on src_req[2] at cycle 0 -> {irq3,irq2,irq1}=3'b011 only in cycle 2, busy=1.
  - eirq at cycle 6 -> src_done=7'h04 in cycle 7, busy=0 in cycle 7.
- Priority: edges on src_req[0] and src_req[5] in the same cycle -> code 6 issued first.
  - After eirq and the GAP cycle -> code 1 issued.
- Mask: mask_din=7'h7E, mask_we=1, then edge on src[0] -> pending=7'h01, no issue.
  - Write mask=7'h7F -> code 1 issued 2 cycles later.
- Lost and stray eirq: two edges on src[3] while src[3] is pending and the controller is in WAIT on code 7 -> lost=1.
  - eirq pulsed in IDLE -> no src_done.
- IRQ_TIMEOUT_EN with TIMEOUT_CYC=8: issue code 2 with no eirq -> timeout=1 after 8 WAIT cycles, busy=0 the following cycle, no src_done.
